// File: rtl/operand_pipe_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared delay pipe and its consumer.
interface operand_pipe_arbiter_if #(
  parameter int unsigned WIDTH = 64
);
  logic             flush;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_op1;
  logic [WIDTH-1:0] a_op2;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_op1;
  logic [WIDTH-1:0] b_op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_op1;
  logic [WIDTH-1:0] out_op2;
  logic             out_src;
  logic             busy;

  modport master (
    output flush, a_valid, a_op1, a_op2, b_valid, b_op1, b_op2, out_ready,
    input  a_ready, b_ready, out_valid, out_op1, out_op2, out_src, busy
  );

  modport slave (
    input  flush, a_valid, a_op1, a_op2, b_valid, b_op1, b_op2, out_ready,
    output a_ready, b_ready, out_valid, out_op1, out_op2, out_src, busy
  );
endinterface

// File: rtl/operand_pipe_arbiter.sv
// Round-robin two-requester front end feeding a 2-stage registered operand delay line
// with valid/ready backpressure and synchronous flush.
module operand_pipe_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_pipe_arbiter_if.slave bus
);

  logic             s1_valid;
  logic             s1_src;
  logic [WIDTH-1:0] s1_op1;
  logic [WIDTH-1:0] s1_op2;
  logic             s2_valid;
  logic             s2_src;
  logic [WIDTH-1:0] s2_op1;
  logic [WIDTH-1:0] s2_op2;
  logic             last_grant;

  logic s2_free;
  logic s1_move;
  logic s1_free;
  logic slot;
  logic a_grant;
  logic b_grant;

  // Advance and grant decisions; rst_n gating keeps both readies low while in reset.
  always_comb begin
    s2_free = 1'b0;
    s1_move = 1'b0;
    s1_free = 1'b0;
    slot    = 1'b0;
    a_grant = 1'b0;
    b_grant = 1'b0;

    s2_free = !s2_valid || bus.out_ready;
    s1_move = s1_valid && s2_free;
    s1_free = !s1_valid || s1_move;
    slot    = s1_free && !bus.flush && rst_n;
    a_grant = slot && bus.a_valid && (!bus.b_valid || last_grant);
    b_grant = slot && bus.b_valid && (!bus.a_valid || !last_grant);
  end

  // Pipeline stages and round-robin pointer; flush only kills the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_src     <= 1'b0;
      s1_op1     <= '0;
      s1_op2     <= '0;
      s2_valid   <= 1'b0;
      s2_src     <= 1'b0;
      s2_op1     <= '0;
      s2_op2     <= '0;
      last_grant <= 1'b1;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_move) begin
        s2_valid <= 1'b1;
        s2_src   <= s1_src;
        s2_op1   <= s1_op1;
        s2_op2   <= s1_op2;
      end else if (bus.out_ready && s2_valid) begin
        s2_valid <= 1'b0;
      end

      if (a_grant || b_grant) begin
        s1_valid   <= 1'b1;
        s1_src     <= b_grant;
        s1_op1     <= b_grant ? bus.b_op1 : bus.a_op1;
        s1_op2     <= b_grant ? bus.b_op2 : bus.a_op2;
        last_grant <= b_grant;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign bus.a_ready   = a_grant;
  assign bus.b_ready   = b_grant;
  assign bus.out_valid = s2_valid;
  assign bus.out_op1   = s2_op1;
  assign bus.out_op2   = s2_op2;
  assign bus.out_src   = s2_src;
  assign bus.busy      = s1_valid || s2_valid;

endmodule
